// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Control, ROM and IF/ID bundle for the MIPS fetch stage.
//               master = fetch stage side, slave = pipeline / ROM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_stall;
    logic                  i_flush;
    logic                  i_branch_taken;
    logic [ADDR_WIDTH-1:0] i_branch_target;
    logic                  i_jump;
    logic [ADDR_WIDTH-1:0] i_jump_target;
    logic [ADDR_WIDTH-1:0] o_rom_addr;
    logic [DATA_WIDTH-1:0] i_rom_data;
    logic [ADDR_WIDTH-1:0] o_pc;
    logic [DATA_WIDTH-1:0] o_if_instr;
    logic [ADDR_WIDTH-1:0] o_if_pc4;
    logic                  o_if_valid;
    logic [31:0]           o_fetch_count;
    logic                  o_misalign;

    modport master (
        input  i_stall, i_flush, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_rom_data,
        output o_rom_addr, o_pc, o_if_instr, o_if_pc4, o_if_valid,
               o_fetch_count, o_misalign
    );

    modport slave (
        output i_stall, i_flush, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_rom_data,
        input  o_rom_addr, o_pc, o_if_instr, o_if_pc4, o_if_valid,
               o_fetch_count, o_misalign
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction fetch: PC, ROM word index, IF/ID register.
//               Optional macro FETCH_ALIGN_CHECK_EN adds a misaligned-target trap.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ROM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_stage_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] c_rom_depth = ADDR_WIDTH'(ROM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step   = ADDR_WIDTH'(4);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_if_instr;
    logic [DATA_WIDTH-1:0] w_if_instr_nxt;
    logic [ADDR_WIDTH-1:0] r_if_pc4;
    logic [ADDR_WIDTH-1:0] w_if_pc4_nxt;
    logic                  r_if_valid;
    logic                  w_if_valid_nxt;
    logic [31:0]           r_fetch_count;
    logic [31:0]           w_fetch_count_nxt;

    logic [ADDR_WIDTH-1:0] w_pc4;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic [DATA_WIDTH-1:0] w_fetched;
    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_pc4      = r_pc + c_pc_step;
    assign w_word_idx = r_pc >> 2;
    // The ROM may alias or return junk past its end, so bound the index here.
    assign w_fetched  = (w_word_idx < c_rom_depth) ? bus.i_rom_data : '0;
    assign w_redirect = bus.i_jump | bus.i_branch_taken;
    assign w_target   = bus.i_jump ? bus.i_jump_target : bus.i_branch_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign_nxt;
    logic w_target_misaligned;

    assign w_target_misaligned = w_redirect && (w_target[1:0] != 2'b00);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_if_instr    <= '0;
            r_if_pc4      <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_instr    <= w_if_instr_nxt;
            r_if_pc4      <= w_if_pc4_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_instr_nxt    = r_if_instr;
        w_if_pc4_nxt      = r_if_pc4;
        w_if_valid_nxt    = r_if_valid;
        w_fetch_count_nxt = r_fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misalign_nxt    = r_misalign;
`endif

        case (r_state)
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_if_instr_nxt = '0;
                w_if_valid_nxt = 1'b0;
            end

            ST_RUN: begin
                // Redirects outrank stall for the PC; stall only freezes sequential flow.
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else if (!bus.i_stall) begin
                    w_pc_nxt = w_pc4;
                end

                if (w_redirect || bus.i_flush) begin
                    w_if_instr_nxt = '0;
                    w_if_valid_nxt = 1'b0;
                end else if (!bus.i_stall) begin
                    w_if_instr_nxt    = w_fetched;
                    w_if_pc4_nxt      = w_pc4;
                    w_if_valid_nxt    = 1'b1;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                end

`ifdef FETCH_ALIGN_CHECK_EN
                if (w_target_misaligned) begin
                    w_state_nxt    = ST_TRAP;
                    w_misalign_nxt = 1'b1;
                end
`endif
            end

`ifdef FETCH_ALIGN_CHECK_EN
            ST_TRAP: begin
                w_if_instr_nxt = '0;
                w_if_valid_nxt = 1'b0;
            end
`endif

            default: begin
                w_state_nxt    = ST_BOOT;
                w_if_instr_nxt = '0;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.o_rom_addr    = w_word_idx;
    assign bus.o_pc          = r_pc;
    assign bus.o_if_instr    = r_if_instr;
    assign bus.o_if_pc4      = r_if_pc4;
    assign bus.o_if_valid    = r_if_valid;
    assign bus.o_fetch_count = r_fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.o_misalign    = r_misalign;
`else
    assign bus.o_misalign    = 1'b0;
`endif

endmodule
`default_nettype wire
